// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern bit serializer slice.
package pattern_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    localparam int WORDS_CNT_W = 16;

endpackage

// File: rtl/pattern_word_fifo.sv
// Show-ahead synchronous word FIFO with flush; head word is always on rdata.
module pattern_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/pattern_bit_serializer.sv
// Buffers parallel words and shifts them out gaplessly, one bit per clock, to the 1010 detector.
module pattern_bit_serializer
    import pattern_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       word_in,
    input  logic                   word_valid,
    output logic                   word_ready,
    input  logic                   flush,
    output logic                   bit_out,
    output logic                   bit_valid,
    output logic                   busy,
    output logic [WORDS_CNT_W-1:0] words_sent
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    ser_state_e             state_q, state_d;
    logic [WIDTH-1:0]       shreg_q, shreg_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [WORDS_CNT_W-1:0] words_sent_q, words_sent_d;
    logic                   bit_out_q, bit_out_d;
    logic                   bit_valid_q, bit_valid_d;
    logic                   busy_q, busy_d;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head_word;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_next;
    logic [IDX_W-1:0] sel_d;

    assign word_ready = !rst && !fifo_full;
    assign push       = word_valid && word_ready;

    pattern_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (word_in),
        .rdata (head_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_idx_d    = bit_idx_q;
        words_sent_d = words_sent_q;
        pop          = 1'b0;
        case (state_q)
            SER_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shreg_d   = head_word;
                    bit_idx_d = '0;
                    state_d   = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (bit_idx_q == IDX_W'(WIDTH - 1)) begin
                    words_sent_d = words_sent_q + 1'b1;
                    // Chain straight into the next queued word so boundary-spanning patterns survive.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shreg_d   = head_word;
                        bit_idx_d = '0;
                    end else begin
                        state_d = SER_IDLE;
                    end
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            default: state_d = SER_IDLE;
        endcase

        if (flush) begin
            state_d      = SER_IDLE;
            pop          = 1'b0;
            words_sent_d = words_sent_q;
        end

        count_next  = flush ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
        sel_d       = MSB_FIRST ? IDX_W'(WIDTH - 1) - bit_idx_d : bit_idx_d;
        bit_valid_d = (state_d == SER_SHIFT);
        bit_out_d   = bit_valid_d && shreg_d[sel_d];
        busy_d      = (state_d == SER_SHIFT) || (count_next != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SER_IDLE;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            words_sent_q <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            words_sent_q <= words_sent_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign busy       = busy_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_pattern_bit_serializer.sv
// Directed bench: three serializer configurations driven by one linear sequence of steps.
module tb_pattern_bit_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // dut_a: WIDTH=4, MSB first
    logic [3:0]  word_a;
    logic        valid_a, flush_a, ready_a, bit_a, bv_a, busy_a;
    logic [15:0] ws_a;
    // dut_b: WIDTH=8, MSB first
    logic [7:0]  word_b;
    logic        valid_b, flush_b, ready_b, bit_b, bv_b, busy_b;
    logic [15:0] ws_b;
    // dut_c: WIDTH=4, LSB first
    logic [3:0]  word_c;
    logic        valid_c, flush_c, ready_c, bit_c, bv_c, busy_c;
    logic [15:0] ws_c;

    pattern_bit_serializer #(.WIDTH(4), .DEPTH(4), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .word_in(word_a), .word_valid(valid_a), .word_ready(ready_a),
        .flush(flush_a), .bit_out(bit_a), .bit_valid(bv_a), .busy(busy_a), .words_sent(ws_a));

    pattern_bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .word_in(word_b), .word_valid(valid_b), .word_ready(ready_b),
        .flush(flush_b), .bit_out(bit_b), .bit_valid(bv_b), .busy(busy_b), .words_sent(ws_b));

    pattern_bit_serializer #(.WIDTH(4), .DEPTH(4), .MSB_FIRST(1'b0)) dut_c (
        .clk(clk), .rst(rst), .word_in(word_c), .word_valid(valid_c), .word_ready(ready_c),
        .flush(flush_c), .bit_out(bit_c), .bit_valid(bv_c), .busy(busy_c), .words_sent(ws_c));

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    logic [3:0]  pat4;
    logic [7:0]  pat8;
    logic [0:63] stream;
    logic [7:0]  rebuilt;
    logic        rdy;
    int          n_acc;
    int          nbits;

    initial begin
        rst = 1'b1;
        word_a = 4'hF; valid_a = 1'b1; flush_a = 1'b0;
        word_b = 8'hFF; valid_b = 1'b1; flush_b = 1'b0;
        word_c = 4'hF; valid_c = 1'b1; flush_c = 1'b0;

        // Reset: words offered during rst are dropped.
        step();
        step();
        check("rst_ready", ready_a, 1'b0);
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        rst = 1'b0;
        step();
        check("rst_bit_valid", bv_a, 1'b0);
        check("rst_bit_out", bit_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_words_sent", ws_a, 16'd0);
        check("rst_ready_after", ready_a, 1'b1);
        check("rst_dropped_b", busy_b, 1'b0);

        // Single word 1010 pushed at edge 0: bits in cycles 1-4.
        pat4 = 4'b1010;
        word_a = pat4; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        check("single_c0_valid", bv_a, 1'b0);
        check("single_c0_busy", busy_a, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("single_bit_valid", bv_a, 1'b1);
            check("single_bit", bit_a, pat4[3-i]);
        end
        step();
        check("single_c5_valid", bv_a, 1'b0);
        check("single_c5_bit", bit_a, 1'b0);
        check("single_words_sent", ws_a, 16'd1);
        check("single_idle_busy", busy_a, 1'b0);

        // Back-to-back A then 5: 8 gapless bits starting in cycle 1.
        pat8 = 8'b1010_0101;
        word_a = 4'hA; valid_a = 1'b1;
        step();
        word_a = 4'h5;
        step();
        valid_a = 1'b0;
        check("b2b_bit_valid", bv_a, 1'b1);
        check("b2b_bit", bit_a, pat8[7]);
        for (int i = 1; i < 8; i++) begin
            step();
            check("b2b_bit_valid", bv_a, 1'b1);
            check("b2b_bit", bit_a, pat8[7-i]);
        end
        step();
        check("b2b_end_valid", bv_a, 1'b0);
        check("b2b_words_sent", ws_a, 16'd3);

        // Flush during the 3rd bit of A with B and C queued.
        word_a = 4'hA; valid_a = 1'b1;
        step();
        word_a = 4'hB;
        step();
        word_a = 4'hC;
        step();
        valid_a = 1'b0;
        step();
        check("flush_pre_bit", bit_a, 1'b1);
        check("flush_pre_valid", bv_a, 1'b1);
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        check("flush_bit_valid", bv_a, 1'b0);
        check("flush_busy", busy_a, 1'b0);
        check("flush_words_sent", ws_a, 16'd3);
        check("flush_ready", ready_a, 1'b1);
        step();
        check("flush_stays_idle", bv_a, 1'b0);

        // LSB-first: 0101 emerges as 1,0,1,0.
        pat4 = 4'b1010;
        word_c = 4'b0101; valid_c = 1'b1;
        step();
        valid_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("lsb_bit_valid", bv_c, 1'b1);
            check("lsb_bit", bit_c, pat4[3-i]);
        end
        step();
        check("lsb_end_valid", bv_c, 1'b0);
        check("lsb_words_sent", ws_c, 16'd1);

        // WIDTH=8 full FIFO: push every edge until six words are accepted.
        n_acc = 0;
        nbits = 0;
        stream = '0;
        for (int e = 0; e < 60; e++) begin
            valid_b = (n_acc < 6);
            word_b  = 8'(8'hA1 + n_acc);
            rdy     = ready_b;
            step();
            if (rdy && valid_b) n_acc++;
            if (e >= 4 && e <= 8) check("full_ready_low", ready_b, 1'b0);
            if (e == 9) check("full_ready_back", ready_b, 1'b1);
            if (e == 10) check("full_sixth_accept", n_acc, 6);
            if (bv_b && nbits < 64) begin
                stream[nbits] = bit_b;
                nbits++;
            end
        end
        valid_b = 1'b0;
        check("full_bit_count", nbits, 48);
        check("full_words_sent", ws_b, 16'd6);
        for (int k = 0; k < 6; k++) begin
            rebuilt = stream[k*8 +: 8];
            check("full_word", rebuilt, 8'(8'hA1 + k));
        end

        // rst mid-shift returns every output to its reset value.
        word_a = 4'hF; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        step();
        step();
        check("rstmid_pre_valid", bv_a, 1'b1);
        rst = 1'b1;
        step();
        check("rstmid_bit_valid", bv_a, 1'b0);
        check("rstmid_bit_out", bit_a, 1'b0);
        check("rstmid_busy", busy_a, 1'b0);
        check("rstmid_words_sent", ws_a, 16'd0);
        check("rstmid_ready", ready_a, 1'b0);
        rst = 1'b0;
        step();
        check("rstmid_ready_after", ready_a, 1'b1);
        check("rstmid_idle", bv_a, 1'b0);

        // words_sent wraps from 0xFFFF to 0.
        force dut_a.words_sent_q = 16'hFFFF;
        #1;
        release dut_a.words_sent_q;
        check("wrap_preload", ws_a, 16'hFFFF);
        word_a = 4'h9; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("wrap_words_sent", ws_a, 16'h0000);
        check("wrap_idle", bv_a, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
